// File: rtl/burst_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : burst_mem_responder
// Purpose  : Line memory serving 256-bit read/write requests as 4x64-bit
//            bursts after a fixed latency.
// Revision : 1.0 - initial release
// ============================================================================
module burst_mem_responder #(
    parameter int DEPTH_BITS = 8,
    parameter int LATENCY    = 3,
    parameter int BURST_LEN  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [31:0] address_i,
    input  logic [63:0] burst_i,
    output logic [63:0] burst_o,
    output logic        resp_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int         c_words     = 4 << DEPTH_BITS;
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_wait   = 2'd1;
    localparam logic [1:0] c_st_burst  = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;
    localparam logic [3:0] c_wait_last = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);
    localparam logic [1:0] c_beat_last = 2'(BURST_LEN - 1);

    logic [63:0] r_mem [0:c_words-1];

    logic [1:0]  r_state;
    logic [3:0]  r_lat;
    logic [1:0]  r_beat;
    logic        r_op_write;
    logic [26:0] r_addr;
    logic        r_resp;
    logic        r_busy;
    logic        r_err;

    logic [DEPTH_BITS+1:0] w_waddr;
    logic                  w_req_held;
    logic                  w_addr_same;
    logic                  w_in_xfer;
    logic                  w_proto_err;
    logic                  w_unused_addr_lsbs;

    assign w_waddr            = {r_addr[DEPTH_BITS-1:0], r_beat};
    assign w_req_held         = r_op_write ? write_i : read_i;
    assign w_addr_same        = (address_i[31:5] == r_addr);
    assign w_in_xfer          = (r_state == c_st_wait) || (r_state == c_st_burst);
    assign w_proto_err        = w_in_xfer && (!w_req_held || !w_addr_same);
    assign w_unused_addr_lsbs = ^address_i[4:0];

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (r_resp && r_op_write) begin
            r_mem[w_waddr] <= burst_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_st_idle;
            r_lat      <= 4'd0;
            r_beat     <= 2'd0;
            r_op_write <= 1'b0;
            r_addr     <= 27'd0;
            r_resp     <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_proto_err) begin
                r_err <= 1'b1;
            end
            case (r_state)
                c_st_idle: begin
                    if (read_i && write_i) begin
                        r_err <= 1'b1;
                    end else if (read_i || write_i) begin
                        r_op_write <= write_i;
                        r_addr     <= address_i[31:5];
                        r_lat      <= 4'd0;
                        r_beat     <= 2'd0;
                        r_busy     <= 1'b1;
                        if (LATENCY <= 1) begin
                            r_state <= c_st_burst;
                            r_resp  <= 1'b1;
                        end else begin
                            r_state <= c_st_wait;
                        end
                    end
                end
                c_st_wait: begin
                    if (r_lat == c_wait_last) begin
                        r_state <= c_st_burst;
                        r_resp  <= 1'b1;
                    end else begin
                        r_lat <= r_lat + 4'd1;
                    end
                end
                c_st_burst: begin
                    r_beat <= r_beat + 2'd1;
                    if (r_beat == c_beat_last) begin
                        r_state <= c_st_done;
                        r_resp  <= 1'b0;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign burst_o = (r_resp && !r_op_write) ? r_mem[w_waddr] : 64'd0;
    assign resp_o  = r_resp;
    assign busy_o  = r_busy;
    assign err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_burst_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_burst_mem_responder
// Purpose  : Directed self-checking bench for burst_mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_burst_mem_responder;

    localparam int c_lat = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        read_req, write_req, write1_req;
    logic [31:0] address;
    logic [63:0] burst_in;
    logic [63:0] burst_out, burst_out1;
    logic        resp, busy, err, resp1, busy1, err1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    burst_mem_responder #(.DEPTH_BITS(8), .LATENCY(c_lat), .BURST_LEN(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .read_i(read_req), .write_i(write_req),
        .address_i(address), .burst_i(burst_in), .burst_o(burst_out),
        .resp_o(resp), .busy_o(busy), .err_o(err)
    );

    burst_mem_responder #(.DEPTH_BITS(8), .LATENCY(1), .BURST_LEN(4)) u_dut_lat1 (
        .clk(clk), .reset_n(reset_n), .read_i(1'b0), .write_i(write1_req),
        .address_i(address), .burst_i(burst_in), .burst_o(burst_out1),
        .resp_o(resp1), .busy_o(busy1), .err_o(err1)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [255:0] line;
    } vec_t;

    vec_t         vecs [7];
    logic [255:0] sb   [256];
    bit           sb_v [256];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Caller is aligned 1ns after a rising edge; returns aligned at the next acceptance slot.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [255:0] wline,
                           output logic [255:0] rline, output int first_cyc);
        rline     = '0;
        first_cyc = -1;
        address   = addr;
        burst_in  = wline[63:0];
        if (wr) write_req = 1'b1;
        else    read_req  = 1'b1;
        for (int c = 0; c < c_lat + 5; c++) begin
            @(negedge clk);
            chk("resp_timing", 64'(resp), 64'(c >= c_lat && c < c_lat + 4));
            chk("busy_timing", 64'(busy), 64'(c >= 1));
            if (resp && c == c_lat) first_cyc = cyc;
            if (resp && !wr && c >= c_lat && c < c_lat + 4) rline[64*(c-c_lat) +: 64] = burst_out;
            @(posedge clk); #1;
            if (c >= c_lat && c < c_lat + 3) burst_in = wline[64*(c-c_lat+1) +: 64];
            if (c == c_lat + 3) begin
                read_req  = 1'b0;
                write_req = 1'b0;
            end
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin : main
        logic [255:0] rline;
        logic [255:0] l1;
        int           fc, prev_fc;

        l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        vecs[0] = '{1'b1, 32'h0000_0040, l1};
        vecs[1] = '{1'b0, 32'h0000_0040, l1};
        vecs[2] = '{1'b1, 32'h0000_2000, {64'hD3, 64'hC2, 64'hB1, 64'hA0}};
        vecs[3] = '{1'b0, 32'h0000_001F, {64'hD3, 64'hC2, 64'hB1, 64'hA0}};
        vecs[4] = '{1'b1, 32'h0000_0060, {64'hFEED_0003, 64'hFEED_0002, 64'hFEED_0001, 64'hFEED_0000}};
        vecs[5] = '{1'b0, 32'h8000_007F, {64'hFEED_0003, 64'hFEED_0002, 64'hFEED_0001, 64'hFEED_0000}};
        vecs[6] = '{1'b0, 32'h0000_0040, l1};
        for (int i = 0; i < 256; i++) sb_v[i] = 1'b0;

        reset_n = 1'b0; read_req = 1'b0; write_req = 1'b0; write1_req = 1'b0;
        address = '0; burst_in = '0;
        repeat (2) @(negedge clk);
        chk("reset_resp", 64'(resp), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_err",  64'(err),  64'd0);
        chk("reset_data", burst_out, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // LATENCY=1 instance: held write request is re-accepted after DONE.
        address = 32'h0000_0040; write1_req = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("lat1_resp", 64'(resp1), 64'((c >= 1 && c <= 4) || c == 7));
            chk("lat1_busy", 64'(busy1), 64'((c >= 1 && c <= 5) || c == 7));
            if (c == 6) chk("lat1_err_hold", 64'(err1), 64'd0);
            @(posedge clk); #1;
        end
        write1_req = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].line, rline, fc);
            if (vecs[i].wr) begin
                sb[vecs[i].addr[12:5]]   = vecs[i].line;
                sb_v[vecs[i].addr[12:5]] = 1'b1;
            end else begin
                for (int b = 0; b < 4; b++)
                    chk($sformatf("vec%0d_beat%0d", i, b), rline[64*b +: 64], vecs[i].line[64*b +: 64]);
            end
        end
        chk("err_clean", 64'(err), 64'd0);

        // Simultaneous read and write in IDLE.
        read_req = 1'b1; write_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("both_resp", 64'(resp), 64'd0);
            chk("both_busy", 64'(busy), 64'd0);
            @(posedge clk); #1;
        end
        read_req = 1'b0; write_req = 1'b0;
        chk("both_err", 64'(err), 64'd1);
        run_txn(1'b0, 32'h0000_0040, '0, rline, fc);
        chk("err_after_read", rline[63:0], l1[63:0]);
        chk("err_sticky", 64'(err), 64'd1);

        // Reset in the middle of a write burst over a 0x55 line.
        run_txn(1'b1, 32'h0000_0080, {4{64'h5555_5555_5555_5555}}, rline, fc);
        address = 32'h0000_0080; burst_in = 64'hAAAA_AAAA_AAAA_AAAA; write_req = 1'b1;
        for (int c = 0; c < c_lat + 2; c++) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        #1;
        chk("midrst_resp", 64'(resp), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_err",  64'(err),  64'd0);
        chk("midrst_data", burst_out, 64'd0);
        write_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        sb[4]   = {64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555,
                   64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA};
        sb_v[4] = 1'b1;
        run_txn(1'b0, 32'h0000_0080, '0, rline, fc);
        for (int b = 0; b < 4; b++)
            chk($sformatf("midrst_beat%0d", b), rline[64*b +: 64], sb[4][64*b +: 64]);

        // Random back-to-back traffic against a line scoreboard.
        prev_fc = -1;
        for (int i = 0; i < 16; i++) begin
            logic [31:0]  a;
            logic [255:0] wl;
            logic [7:0]   idx;
            bit           wr;
            idx = 8'($urandom_range(0, 7));
            a   = ($urandom & 32'hFFFF_E01F) | (32'(idx) << 5);
            wr  = !sb_v[idx] || ($urandom_range(0, 1) == 1);
            wl  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_txn(wr, a, wl, rline, fc);
            if (prev_fc >= 0) chk("b2b_gap", 64'(fc - prev_fc), 64'(c_lat + 5));
            prev_fc = fc;
            if (wr) begin
                sb[idx]   = wl;
                sb_v[idx] = 1'b1;
            end else begin
                chk($sformatf("rand%0d_line_lo", i), rline[127:0], sb[idx][127:0]);
                chk($sformatf("rand%0d_line_hi", i), rline[255:128], sb[idx][255:128]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
